// File: rtl/registro_casas_param.sv
// registro_casas_param: goal-home occupancy register with count, hit flag and timed level-full hold
module registro_casas_param #(
    parameter int NUM_CASAS = 8,
    parameter int HOLD_CYCLES = 16,
    localparam int CW = $clog2(NUM_CASAS + 1),
    localparam int HW = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                 SC_RegCASAS_CLOCK_50,
    input  logic                 SC_RegCASAS_RESET_InHigh,
    input  logic                 SC_RegCASAS_clear_In,
    input  logic                 SC_RegCASAS_arrive_In,
    input  logic [NUM_CASAS-1:0] SC_RegCASAS_pos_In,
    output logic [NUM_CASAS-1:0] SC_RegCASAS_data_Out,
    output logic [CW-1:0]        SC_RegCASAS_count_Out,
    output logic                 SC_RegCASAS_full_Out,
    output logic                 SC_RegCASAS_hit_Out,
    output logic                 SC_RegCASAS_levelDone_Out
);
    typedef enum logic {RUN, FULL} state_t;

    state_t               state, state_n;
    logic [NUM_CASAS-1:0] data, data_n;
    logic [CW-1:0]        count, count_n;
    logic [HW-1:0]        hold, hold_n;
    logic                 hit, hit_n;
    logic                 level_done, level_done_n;
    logic                 one_hot;
    logic                 free;

    assign one_hot = (SC_RegCASAS_pos_In != '0) &&
                     ((SC_RegCASAS_pos_In & (SC_RegCASAS_pos_In - NUM_CASAS'(1))) == '0);
    assign free    = (data & SC_RegCASAS_pos_In) == '0;

    // State and output registers; everything the outside sees comes straight from here
    always_ff @(posedge SC_RegCASAS_CLOCK_50 or posedge SC_RegCASAS_RESET_InHigh) begin
        if (SC_RegCASAS_RESET_InHigh) begin
            state      <= RUN;
            data       <= '0;
            count      <= '0;
            hold       <= '0;
            hit        <= 1'b0;
            level_done <= 1'b0;
        end else begin
            state      <= state_n;
            data       <= data_n;
            count      <= count_n;
            hold       <= hold_n;
            hit        <= hit_n;
            level_done <= level_done_n;
        end
    end

    // Next-state logic: accept arrivals in RUN, count down the hold in FULL, clear wins over both
    always_comb begin
        state_n      = state;
        data_n       = data;
        count_n      = count;
        hold_n       = hold;
        hit_n        = 1'b0;
        level_done_n = 1'b0;
        if (SC_RegCASAS_clear_In) begin
            state_n = RUN;
            data_n  = '0;
            count_n = '0;
            hold_n  = '0;
        end else if (state == RUN) begin
            if (SC_RegCASAS_arrive_In) begin
                if (one_hot && free) begin
                    data_n  = data | SC_RegCASAS_pos_In;
                    count_n = count + CW'(1);
                    if (&data_n) begin
                        state_n = FULL;
                        hold_n  = HW'(HOLD_CYCLES - 1);
                    end
                end else begin
                    hit_n = 1'b1;
                end
            end
        end else if (hold == '0) begin
            state_n      = RUN;
            data_n       = '0;
            count_n      = '0;
            level_done_n = 1'b1;
        end else begin
            hold_n = hold - HW'(1);
        end
    end

    assign SC_RegCASAS_data_Out      = data;
    assign SC_RegCASAS_count_Out     = count;
    assign SC_RegCASAS_full_Out      = state == FULL;
    assign SC_RegCASAS_hit_Out       = hit;
    assign SC_RegCASAS_levelDone_Out = level_done;
endmodule

// File: tb/tb_registro_casas_param.sv
// tb_registro_casas_param: vector table plus hand sequences, checked through an expected-value queue
module tb_registro_casas_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       arrive = 1'b0;
    logic [7:0] pos = '0;
    logic [7:0] data;
    logic [3:0] count;
    logic       full, hit, level_done;

    int passed = 0;
    int total = 0;

    typedef struct {
        logic        arrive;
        logic        clear;
        logic [7:0]  pos;
        logic [14:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [14:0] sb[$];

    registro_casas_param #(.NUM_CASAS(8), .HOLD_CYCLES(16)) dut (
        .SC_RegCASAS_CLOCK_50(clk),
        .SC_RegCASAS_RESET_InHigh(rst),
        .SC_RegCASAS_clear_In(clear),
        .SC_RegCASAS_arrive_In(arrive),
        .SC_RegCASAS_pos_In(pos),
        .SC_RegCASAS_data_Out(data),
        .SC_RegCASAS_count_Out(count),
        .SC_RegCASAS_full_Out(full),
        .SC_RegCASAS_hit_Out(hit),
        .SC_RegCASAS_levelDone_Out(level_done)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] mk(input logic [7:0] d, input logic [3:0] c,
                                       input logic f, input logic h, input logic l);
        return {d, c, f, h, l};
    endfunction

    function automatic vec_t v(input logic a, input logic c, input logic [7:0] p, input logic [14:0] e);
        vec_t r;
        r.arrive = a;
        r.clear = c;
        r.pos = p;
        r.exp = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [14:0] req);
        logic [14:0] act;
        act = {data, count, full, hit, level_done};
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got data=%h count=%0d full=%b hit=%b ld=%b, want data=%h count=%0d full=%b hit=%b ld=%b",
                      name, act[14:7], act[6:3], act[2], act[1], act[0],
                      req[14:7], req[6:3], req[2], req[1], req[0]);
    endtask

    task automatic step(input string name, input vec_t x);
        @(negedge clk);
        arrive = x.arrive;
        clear = x.clear;
        pos = x.pos;
        sb.push_back(x.exp);
        @(posedge clk);
        #1;
        check(name, sb.pop_front());
    endtask

    task automatic fill_to_full(input string name);
        logic [7:0] d = '0;
        for (int i = 0; i < 8; i++) begin
            d[i] = 1'b1;
            step(name, v(1, 0, 8'(1 << i), mk(d, 4'(i + 1), i == 7, 0, 0)));
        end
    endtask

    initial begin
        #1;
        check("reset_asserted", mk(0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step("idle_after_reset", v(0, 0, 8'h00, mk(0, 0, 0, 0, 0)));

        vecs.push_back(v(1, 0, 8'h04, mk(8'h04, 1, 0, 0, 0)));
        vecs.push_back(v(1, 0, 8'h04, mk(8'h04, 1, 0, 1, 0)));
        vecs.push_back(v(0, 0, 8'h04, mk(8'h04, 1, 0, 0, 0)));
        vecs.push_back(v(1, 0, 8'h00, mk(8'h04, 1, 0, 1, 0)));
        vecs.push_back(v(0, 0, 8'h00, mk(8'h04, 1, 0, 0, 0)));
        vecs.push_back(v(1, 0, 8'h05, mk(8'h04, 1, 0, 1, 0)));
        vecs.push_back(v(1, 0, 8'h80, mk(8'h84, 2, 0, 0, 0)));
        vecs.push_back(v(0, 1, 8'h00, mk(8'h00, 0, 0, 0, 0)));
        vecs.push_back(v(1, 0, 8'h04, mk(8'h04, 1, 0, 0, 0)));
        vecs.push_back(v(1, 0, 8'h08, mk(8'h0C, 2, 0, 0, 0)));
        vecs.push_back(v(1, 0, 8'h10, mk(8'h1C, 3, 0, 0, 0)));
        vecs.push_back(v(1, 0, 8'h20, mk(8'h3C, 4, 0, 0, 0)));
        vecs.push_back(v(1, 1, 8'h01, mk(8'h00, 0, 0, 0, 0)));
        vecs.push_back(v(1, 0, 8'h03, mk(8'h00, 0, 0, 1, 0)));
        vecs.push_back(v(1, 1, 8'h03, mk(8'h00, 0, 0, 0, 0)));
        foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

        fill_to_full("fill");
        for (int i = 0; i < 15; i++) step("hold_with_arrivals", v(1, 0, 8'h01, mk(8'hFF, 8, 1, 0, 0)));
        step("hold_expire", v(1, 0, 8'h01, mk(8'h00, 0, 0, 0, 1)));
        step("after_level_done", v(0, 0, 8'h00, mk(8'h00, 0, 0, 0, 0)));

        fill_to_full("fill2");
        for (int i = 0; i < 3; i++) step("hold2", v(0, 0, 8'h00, mk(8'hFF, 8, 1, 0, 0)));
        step("clear_in_full", v(0, 1, 8'h00, mk(8'h00, 0, 0, 0, 0)));
        step("after_clear_full", v(0, 0, 8'h00, mk(8'h00, 0, 0, 0, 0)));

        fill_to_full("fill3");
        for (int i = 0; i < 5; i++) step("hold3", v(0, 0, 8'h00, mk(8'hFF, 8, 1, 0, 0)));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_mid_full", mk(0, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step("post_reset_idle", v(0, 0, 8'h00, mk(0, 0, 0, 0, 0)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/registro_casas_param.md
# registro_casas_param

Parametrised home-occupancy register for the Frogger playfield: it records which of the NUM_CASAS goal homes are occupied by a frog, keeps a running occupancy count, and flags arrivals on an already-occupied home. When every home is filled it holds a "level full" state for a programmable number of cycles, then auto-clears and emits a level-done pulse. It sits between the frog-position logic (home-row detection) and the game-control FSM / display, and replaces the fixed 8-bit combinational OR accumulation of home bits.

## Interface
- NUM_CASAS, 8, number of homes; must be ≥ 2.
- HOLD_CYCLES, 16, cycles the full state is held before auto-clear; must be ≥ 1.
- CW (localparam), $clog2(NUM_CASAS+1), count width.
- HW (localparam), $clog2(HOLD_CYCLES+1), hold-counter width.

- SC_RegCASAS_CLOCK_50  in  1  system clock; all state changes on rising edge.
- SC_RegCASAS_RESET_InHigh  in  1  one clock; reset is asynchronous and active-high.
- SC_RegCASAS_clear_In  in  1  synchronous level clear (new game / frog-death restart).
- SC_RegCASAS_arrive_In  in  1  one-cycle strobe: frog reached the home row this cycle.
- SC_RegCASAS_pos_In  in  NUM_CASAS  one-hot home index of the arriving frog; sampled only when arrive_In=1.
- SC_RegCASAS_data_Out  out  NUM_CASAS  occupancy vector, bit i = home i occupied.
- SC_RegCASAS_count_Out  out  CW  number of occupied homes (0..NUM_CASAS).
- SC_RegCASAS_full_Out  out  1  high while in FULL state.
- SC_RegCASAS_hit_Out  out  1  one-cycle pulse: rejected arrival (occupied home or pos not one-hot).
- SC_RegCASAS_levelDone_Out  out  1  one-cycle pulse: level completed, homes auto-cleared.

## Operation
- Reset (async): data=0, count=0, full=0, hit=0, levelDone=0, hold counter=0, state RUN.
- States: RUN, FULL.
- RUN, arrive=1, pos one-hot, target bit 0: target bit set, count+1. If resulting data is all ones → FULL, hold counter loaded with HOLD_CYCLES-1.
- RUN, arrive=1, target bit already 1 or pos not one-hot (zero or ≥2 bits set): hit=1 next cycle, data/count unchanged.
- RUN, arrive=0: no change; hit=0.
- FULL: arrive ignored entirely (no set, no hit). Hold counter decrements each cycle; when it is 0, next edge: data=0, count=0, levelDone=1, state RUN.
- clear_In=1 (any state): next edge data=0, count=0, hold counter=0, state RUN, full=0; hit=0 and levelDone=0 that cycle. Clear has priority over arrive and over hold expiry.
- count_Out is a register updated together with data_Out; invariant count == popcount(data) at all times.
- hit and levelDone are registered pulses, never high two consecutive cycles from a single event; hit and levelDone never high in the same cycle.

## Timing
- All outputs registered; arrival sampled at edge k → data/count/hit valid after edge k (latency 1).
- Final arrival at edge k: last bit set and full rises at edge k together.
- full stays high exactly HOLD_CYCLES cycles (edges k+1..k+HOLD_CYCLES decrement/expire); at edge k+HOLD_CYCLES data clears, full falls, levelDone high for that one cycle.
- HOLD_CYCLES=1: full high one cycle, clear and levelDone on the next edge.
- Back-to-back arrivals on consecutive cycles each processed independently.
- Reset asserted mid-FULL: all outputs 0 immediately, no levelDone generated.
- No combinational path from any input to any output.

## Test plan
- Reset → all outputs 0; release, idle 10 cycles → outputs remain 0.
- NUM_CASAS=8: arrive pos=8'b0000_0100 → data=8'h04, count=1, hit=0; repeat same pos → hit pulse 1 cycle, data=8'h04, count=1.
- arrive pos=8'h00 and pos=8'h05 → hit pulse each, data/count unchanged.
- Fill homes 0..7 one per cycle → full rises with data=8'hFF, count=8; arrivals during FULL produce no hit; after 16 cycles data=0, count=0, full=0, levelDone high exactly 1 cycle.
- With data=8'h3C, assert clear together with arrive pos=8'h01 → next cycle data=0, count=0, hit=0, levelDone=0.
- Reach FULL, assert RESET_InHigh asynchronously after 5 hold cycles → outputs 0 before next edge; no levelDone after release.
